seg_scan_driver: RTL and testbench

- Time-multiplexed driver for the board's 6-digit common-anode seven-segment display.
- Sits directly downstream of the per-digit code translation stage, which delivers active-low 7-bit segment codes.
- Scans one digit per slot and inserts an anti-ghosting blank gap at the end of each slot.
- Supports per-digit enable, decimal point and blink.
- All outputs are registered; inputs are sampled once per slot so a slot never shows a torn code.

---
 rtl/seg_scan_driver.sv | 137 +++++++++++++
 tb/tb_seg_scan_driver.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode 7-segment scanner.
// One digit per slot: LOAD, SHOW, then a BLANK gap.
module seg_scan_driver #(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int SCAN_FREQ    = 1000,
  parameter int BLANK_CYC    = 2500,
  parameter int NUM_DIGITS   = 6,
  parameter int BLINK_FRAMES = 83
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7*NUM_DIGITS-1:0] seg_codes,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [NUM_DIGITS-1:0]   blink_en,
  output logic [NUM_DIGITS-1:0]   seg_sel,
  output logic [7:0]              seg_data,
  output logic                    frame_start
);

  localparam int SLOT_CYC = CLK_FREQ / SCAN_FREQ;
  localparam int SHOW_END = SLOT_CYC - BLANK_CYC - 1;
  localparam int SW = $clog2(SLOT_CYC);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  typedef enum logic [1:0] {
    LOAD,
    SHOW,
    BLANK
  } state_t;

  state_t          state;
  logic [SW-1:0]   slot_cnt;
  logic [IW-1:0]   digit_idx;
  logic [FW-1:0]   frame_cnt;
  logic            blink_phase;

  logic [6:0]      code;
  logic            dp;
  logic            en;
  logic            bl;
  logic            ph;

  logic [6:0]      cur_code;
  logic            cur_dp;
  logic            cur_en;
  logic            cur_bl;
  logic            lit;
  logic [NUM_DIGITS-1:0] sel_on;

  // Constant-index mux keeps every select inside the input vectors.
  always_comb begin
    cur_code = 7'h7F;
    cur_dp   = 1'b0;
    cur_en   = 1'b0;
    cur_bl   = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit_idx == IW'(i)) begin
        cur_code = seg_codes[7*i +: 7];
        cur_dp   = dp_in[i];
        cur_en   = digit_en[i];
        cur_bl   = blink_en[i];
      end
    end
  end

  assign lit    = en & ~(bl & ph);
  assign sel_on = ~(NUM_DIGITS'(1) << digit_idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= LOAD;
      slot_cnt    <= '0;
      digit_idx   <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
      code        <= 7'h7F;
      dp          <= 1'b0;
      en          <= 1'b0;
      bl          <= 1'b0;
      ph          <= 1'b0;
      seg_sel     <= '1;
      seg_data    <= 8'hFF;
      frame_start <= 1'b0;
    end else begin
      seg_sel     <= '1;
      seg_data    <= 8'hFF;
      frame_start <= 1'b0;
      unique case (state)
        LOAD: begin
          code        <= cur_code;
          dp          <= cur_dp;
          en          <= cur_en;
          bl          <= cur_bl;
          ph          <= blink_phase;
          frame_start <= (digit_idx == '0);
          slot_cnt    <= SW'(1);
          state       <= SHOW;
        end
        SHOW: begin
          if (lit) begin
            seg_sel  <= sel_on;
            seg_data <= {~dp, code};
          end
          slot_cnt <= slot_cnt + SW'(1);
          if (slot_cnt == SW'(SHOW_END))
            state <= BLANK;
        end
        BLANK: begin
          if (slot_cnt == SW'(SLOT_CYC - 1)) begin
            slot_cnt <= '0;
            state    <= LOAD;
            if (digit_idx == IW'(NUM_DIGITS - 1)) begin
              digit_idx <= '0;
              if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
              end else begin
                frame_cnt <= frame_cnt + FW'(1);
              end
            end else begin
              digit_idx <= digit_idx + IW'(1);
            end
          end else begin
            slot_cnt <= slot_cnt + SW'(1);
          end
        end
        default: begin
          state    <= LOAD;
          slot_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: vector table plus
// scoreboard of expected per-cycle outputs.
module tb_seg_scan_driver;

  localparam int ND    = 6;
  localparam int SLOT  = 10;
  localparam int BLANK = 2;
  localparam int BF    = 2;
  localparam int FRAME = ND * SLOT;

  localparam logic [41:0] CODES =
    {7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h08};
  localparam logic [6:0] NEWC = 7'h02;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [41:0] seg_codes;
  logic [5:0]  dp_in;
  logic [5:0]  digit_en;
  logic [5:0]  blink_en;
  logic [5:0]  seg_sel;
  logic [7:0]  seg_data;
  logic        frame_start;

  seg_scan_driver #(
    .CLK_FREQ    (1000),
    .SCAN_FREQ   (100),
    .BLANK_CYC   (BLANK),
    .NUM_DIGITS  (ND),
    .BLINK_FRAMES(BF)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seg_codes  (seg_codes),
    .dp_in      (dp_in),
    .digit_en   (digit_en),
    .blink_en   (blink_en),
    .seg_sel    (seg_sel),
    .seg_data   (seg_data),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [41:0]     codes;
    logic [5:0]      dp;
    logic [5:0]      en;
    logic [5:0]      bl;
    int              frames;
    bit              chg;
    logic [5:0][7:0] lit;
  } vec_t;

  typedef struct {
    logic [5:0] sel;
    logic [7:0] data;
    logic       fs;
  } exp_t;

  vec_t vecs [4];
  exp_t sbq [$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   lit_seen [6];

  logic [6:0] m_code;
  logic       m_dp, m_en, m_bl, m_ph;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h",
               name, cyc, act, req);
    end
  endtask

  // Reference: position derived from cycle count since release.
  task automatic model_push();
    int s, idx, fr;
    exp_t e;
    s   = cyc % SLOT;
    idx = (cyc / SLOT) % ND;
    fr  = cyc / FRAME;
    e.sel  = 6'h3F;
    e.data = 8'hFF;
    e.fs   = 1'b0;
    if (s == 0) begin
      m_code = seg_codes[7*idx +: 7];
      m_dp   = dp_in[idx];
      m_en   = digit_en[idx];
      m_bl   = blink_en[idx];
      m_ph   = ((fr / BF) % 2) == 1;
      e.fs   = (idx == 0);
    end else if (s < SLOT - BLANK && m_en && !(m_bl && m_ph)) begin
      e.sel  = ~(6'd1 << idx);
      e.data = {~m_dp, m_code};
    end
    sbq.push_back(e);
  endtask

  task automatic step(input int v, input bit chg);
    exp_t e;
    int n;
    @(posedge clk);
    model_push();
    cyc++;
    @(negedge clk);
    n = cyc - 1;
    if (sbq.size() == 0) begin
      chk("sb_empty", 0, 1);
    end else begin
      e = sbq.pop_front();
      chk("seg_sel", 32'(seg_sel), 32'(e.sel));
      chk("seg_data", 32'(seg_data), 32'(e.data));
      chk("frame_start", 32'(frame_start), 32'(e.fs));
    end
    chk("one_low", 32'($countones(~seg_sel) <= 1), 1);
    for (int i = 0; i < ND; i++)
      if (!seg_sel[i]) lit_seen[i]++;
    if (v == 0 && n == 3) begin
      chk("first_sel", 32'(seg_sel), 32'(6'b111110));
      chk("first_data", 32'(seg_data), 32'h88);
    end
    if (v == 0 && n == 10)
      chk("load_d1_off", 32'(seg_sel), 32'h3F);
    if (v == 0 && n == 60)
      chk("frame2_fs", 32'(frame_start), 1);
    if (v == 1 && n == 13)
      chk("dp_d1", 32'(seg_data), 32'h79);
    if (v == 1 && n == 23)
      chk("dis_d2", 32'(seg_sel), 32'h3F);
    if (v == 3 && n == 123)
      chk("blink_dark", 32'(seg_sel), 32'h3F);
    if (v == 3 && n == 133)
      chk("blink_other", 32'(seg_sel), 32'(6'b111101));
    if (v == 3 && n == 243)
      chk("blink_back", 32'(seg_data), 32'h88);
    if (chg && n == 35)
      chk("hold_old", 32'(seg_data), 32'hB0);
    if (chg && n == 95)
      chk("new_code", 32'(seg_data), 32'(8'h82));
    if (chg && n == 34)
      seg_codes[27:21] = NEWC;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_sel", 32'(seg_sel), 32'h3F);
    chk("rst_data", 32'(seg_data), 32'hFF);
    chk("rst_fs", 32'(frame_start), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    sbq.delete();
    for (int i = 0; i < ND; i++) lit_seen[i] = 0;
  endtask

  task automatic apply(input vec_t v);
    seg_codes = v.codes;
    dp_in     = v.dp;
    digit_en  = v.en;
    blink_en  = v.bl;
  endtask

  initial begin
    vecs[0] = '{codes: CODES, dp: 6'h00, en: 6'h3F, bl: 6'h00,
                frames: 2, chg: 1'b0,
                lit: {8'd14, 8'd14, 8'd14, 8'd14, 8'd14, 8'd14}};
    vecs[1] = '{codes: CODES, dp: 6'b000010, en: 6'b111011,
                bl: 6'h00, frames: 1, chg: 1'b0,
                lit: {8'd7, 8'd7, 8'd7, 8'd0, 8'd7, 8'd7}};
    vecs[2] = '{codes: CODES, dp: 6'h00, en: 6'h3F, bl: 6'h00,
                frames: 2, chg: 1'b1,
                lit: {8'd14, 8'd14, 8'd14, 8'd14, 8'd14, 8'd14}};
    vecs[3] = '{codes: CODES, dp: 6'h00, en: 6'h3F,
                bl: 6'b000001, frames: 6, chg: 1'b0,
                lit: {8'd42, 8'd42, 8'd42, 8'd42, 8'd42, 8'd28}};

    apply(vecs[0]);
    for (int v = 0; v < 4; v++) begin
      apply(vecs[v]);
      do_reset();
      for (int c = 0; c < vecs[v].frames * FRAME; c++)
        step(v, vecs[v].chg);
      for (int i = 0; i < ND; i++)
        chk("lit_cnt", 32'(lit_seen[i]), 32'(vecs[v].lit[i]));
    end

    // Asynchronous reset in the middle of digit 4's SHOW window.
    apply(vecs[0]);
    do_reset();
    for (int c = 0; c < 46; c++) step(-1, 1'b0);
    chk("pre_rst_lit", 32'(seg_sel), 32'(6'b101111));
    rst_n = 1'b0;
    #1;
    chk("async_sel", 32'(seg_sel), 32'h3F);
    chk("async_data", 32'(seg_data), 32'hFF);
    chk("async_fs", 32'(frame_start), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    sbq.delete();
    for (int c = 0; c < 12; c++) step(-1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
